// File: rtl/matrix_ls_sequencer.sv
// Matrix load/store sequencer: moves ROWS rows between the matrix register file
// and memory, one request per row, with a row address that advances by a byte stride.
module matrix_ls_sequencer #(
  parameter int ROWS   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int MREG_W = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_load,
  input  logic [MREG_W-1:0]        cmd_mreg,
  input  logic [ADDR_W-1:0]        cmd_base,
  input  logic [ADDR_W-1:0]        cmd_stride,
  output logic                     mem_req,
  output logic                     mem_wen,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_hit,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     mrf_wen,
  output logic                     mrf_ren,
  output logic [MREG_W-1:0]        mrf_reg,
  output logic [$clog2(ROWS)-1:0]  mrf_row,
  output logic [DATA_W-1:0]        mrf_wdata,
  input  logic [DATA_W-1:0]        mrf_rdata,
  output logic                     busy,
  output logic                     done
);

  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, RDREG, REQ, DONE} state_t;

  state_t              state;
  logic                load_q;
  logic [MREG_W-1:0]   mreg_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   stride_q;
  logic [ROW_W-1:0]    row_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                cap_q;

  // NOTE: every register here is written with <= so all of them update together
  // from the values present before the edge; blocking here would create ordering races.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      load_q   <= 1'b0;
      mreg_q   <= '0;
      addr_q   <= '0;
      stride_q <= '0;
      row_q    <= '0;
      wdata_q  <= '0;
      cap_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            load_q   <= cmd_load;
            mreg_q   <= cmd_mreg;
            addr_q   <= cmd_base;
            stride_q <= cmd_stride;
            row_q    <= '0;
            state    <= cmd_load ? REQ : RDREG;
          end
        end
        RDREG: begin
          cap_q <= 1'b1;
          state <= REQ;
        end
        REQ: begin
          // RF read data arrives one cycle after mrf_ren, i.e. in the first REQ cycle.
          if (cap_q) begin
            wdata_q <= mrf_rdata;
            cap_q   <= 1'b0;
          end
          if (mem_hit) begin
            if (row_q == LAST_ROW) begin
              state <= DONE;
            end else begin
              row_q  <= row_q + ROW_W'(1);
              addr_q <= addr_q + stride_q;
              state  <= load_q ? REQ : RDREG;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; only the RF write strobe follows mem_hit.
  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign done      = (state == DONE);
  assign mrf_ren   = (state == RDREG);
  assign mem_req   = (state == REQ);
  assign mem_wen   = mem_req & ~load_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = cap_q ? mrf_rdata : wdata_q;
  assign mrf_wen   = mem_req & load_q & mem_hit;
  assign mrf_wdata = mrf_wen ? mem_rdata : '0;
  assign mrf_reg   = mreg_q;
  assign mrf_row   = row_q;

endmodule

// File: tb/tb_matrix_ls_sequencer.sv
// Self-checking bench for matrix_ls_sequencer: table vectors, corner sequences and
// random commands checked against a per-row transaction model.
module tb_matrix_ls_sequencer;

  localparam int ROWS   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int MREG_W = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_load = 1'b0;
  logic [MREG_W-1:0] cmd_mreg = '0;
  logic [ADDR_W-1:0] cmd_base = '0;
  logic [ADDR_W-1:0] cmd_stride = '0;
  logic              mem_req, mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_hit = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mrf_wen, mrf_ren;
  logic [MREG_W-1:0] mrf_reg;
  logic [1:0]        mrf_row;
  logic [DATA_W-1:0] mrf_wdata;
  logic [DATA_W-1:0] mrf_rdata = '0;
  logic              busy, done;

  matrix_ls_sequencer #(.ROWS(ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MREG_W(MREG_W)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_mreg(cmd_mreg), .cmd_base(cmd_base), .cmd_stride(cmd_stride),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_hit(mem_hit), .mem_rdata(mem_rdata),
    .mrf_wen(mrf_wen), .mrf_ren(mrf_ren), .mrf_reg(mrf_reg), .mrf_row(mrf_row),
    .mrf_wdata(mrf_wdata), .mrf_rdata(mrf_rdata),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          load;
    logic [3:0]  mreg;
    logic [31:0] base;
    logic [31:0] stride;
    int          lat;
    logic [31:0] exp_last;
    int          exp_done;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  logic [DATA_W-1:0] rf [16][ROWS];
  vec_t        m;
  int          k, age, done_count, done_at, acc_cyc, block_row;
  bit          req_prev, hit_prev, ren_prev;
  logic [3:0]  ren_reg;
  logic [1:0]  ren_row;
  logic [31:0] last_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge CLK);
    cyc++;
    #1;
  endtask

  // Memory and register-file responder plus per-row expectations for the current cycle.
  task automatic respond();
    bit hit;
    logic [31:0] ea;
    if (ren_prev) mrf_rdata = rf[ren_reg][ren_row];
    else          mrf_rdata = {$urandom(), $urandom()};
    ren_prev = mrf_ren;
    ren_reg  = mrf_reg;
    ren_row  = mrf_row;
    if (mrf_ren) begin
      check("ren_row", 64'(mrf_row), 64'(k));
      check("ren_reg", 64'(mrf_reg), 64'(m.mreg));
    end
    hit = 1'b0;
    if (mem_req) begin
      if (!req_prev || hit_prev) age = 0;
      else age++;
      hit = (age >= m.lat) && (k != block_row);
    end
    mem_hit   = hit;
    mem_rdata = {$urandom(), $urandom()};
    #1;
    if (hit) begin
      ea = m.base + m.stride * 32'(k);
      check("mem_addr", 64'(mem_addr), 64'(ea));
      check("mem_wen", 64'(mem_wen), 64'(!m.load));
      if (!m.load) begin
        check("mem_wdata", mem_wdata, rf[m.mreg][k]);
      end else begin
        check("mrf_wen", 64'(mrf_wen), 64'(1));
        check("mrf_wdata", mrf_wdata, mem_rdata);
        check("mrf_row", 64'(mrf_row), 64'(k));
        check("mrf_reg", 64'(mrf_reg), 64'(m.mreg));
      end
      last_addr = mem_addr;
      k++;
    end else begin
      check("mrf_wen_quiet", 64'(mrf_wen), 64'(0));
    end
    hit_prev = hit;
    req_prev = mem_req;
    if (done) begin
      done_count++;
      done_at = cyc;
    end
  endtask

  task automatic start_cmd(input vec_t v);
    m = v;
    k = 0; age = 0; req_prev = 0; hit_prev = 0;
    done_count = 0; done_at = -1;
    cmd_valid  = 1'b1;
    cmd_load   = v.load;
    cmd_mreg   = v.mreg;
    cmd_base   = v.base;
    cmd_stride = v.stride;
    acc_cyc    = cyc;
    check("ready_at_accept", 64'(cmd_ready), 64'(1));
    respond();
    tick();
  endtask

  task automatic run_cmd(input vec_t v, input bit hold, input vec_t nxt);
    bit seen;
    start_cmd(v);
    if (hold) begin
      cmd_load = nxt.load; cmd_mreg = nxt.mreg; cmd_base = nxt.base; cmd_stride = nxt.stride;
    end else begin
      cmd_valid = 1'b0;
    end
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      respond();
      if (done_count != 0) seen = 1;
      else tick();
    end
    if (!seen) check("done_timeout", 64'(0), 64'(1));
    check("rows_moved", 64'(k), 64'(ROWS));
    check("done_cycle", 64'(done_at - acc_cyc), 64'(v.exp_done));
    check("last_addr", 64'(last_addr), 64'(v.exp_last));
    tick();
    check("ready_after_done", 64'(cmd_ready), 64'(1));
    check("done_single", 64'(done), 64'(0));
    check("busy_after_done", 64'(busy), 64'(0));
    check("req_after_done", 64'(mem_req), 64'(0));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req"},   64'(mem_req),   64'(0));
    check({tag, "_wen"},   64'({mem_wen, mrf_wen, mrf_ren}), 64'(0));
    check({tag, "_done"},  64'({done, busy}), 64'(0));
    check({tag, "_ready"}, 64'(cmd_ready), 64'(1));
  endtask

  vec_t vecs[6];
  vec_t none;

  initial begin
    int prev_acc;
    vec_t r;
    none = '{0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0};
    block_row = -1;
    ren_prev = 0;
    for (int g = 0; g < 16; g++)
      for (int j = 0; j < ROWS; j++) rf[g][j] = {$urandom(), $urandom()};
    for (int j = 0; j < ROWS; j++) rf[5][j] = 64'hA0 + 64'(j);

    //        load mreg  base          stride        lat last           done
    vecs[0] = '{1, 4'd3,  32'h0000_0100, 32'h40,       2, 32'h0000_01C0, 13};
    vecs[1] = '{0, 4'd5,  32'h0000_2000, 32'h8,        0, 32'h0000_2018,  9};
    vecs[2] = '{1, 4'd1,  32'hFFFF_FFC0, 32'h20,       0, 32'h0000_0020,  5};
    vecs[3] = '{1, 4'd7,  32'h0000_0055, 32'h0,        1, 32'h0000_0055,  9};
    vecs[4] = '{0, 4'd2,  32'h0000_0010, 32'h100,      3, 32'h0000_0310, 21};
    vecs[5] = '{0, 4'd15, 32'hFFFF_FFF8, 32'h4,        1, 32'h0000_0004, 13};

    // Reset: every output except cmd_ready must be low.
    RST = 1'b1;
    tick(); tick();
    check_quiet("reset");
    check("reset_addr", 64'(mem_addr), 64'(0));
    check("reset_data", {mem_wdata ^ mrf_wdata}, 64'(0));
    check("reset_idx", 64'({mrf_reg, mrf_row}), 64'(0));
    RST = 1'b0;
    tick();
    check_quiet("post_reset");

    for (int i = 0; i < 6; i++) run_cmd(vecs[i], 1'b0, none);

    // Reset while row 2 waits for its hit: abort, no done, restart cleanly.
    block_row = 2;
    start_cmd('{1, 4'd9, 32'h0000_4000, 32'h10, 0, 32'h0000_4030, 5});
    cmd_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      respond();
      if (k == 2 && mem_req && age >= 2) break;
      tick();
    end
    check("abort_waiting_row", 64'(k), 64'(2));
    RST = 1'b1;
    mem_hit = 1'b0;
    tick();
    check_quiet("abort_reset");
    RST = 1'b0;
    tick();
    check_quiet("abort_release");
    check("abort_no_done", 64'(done_count), 64'(0));
    block_row = -1;
    run_cmd('{1, 4'd9, 32'h0000_4000, 32'h10, 0, 32'h0000_4030, 5}, 1'b0, none);

    // cmd_valid held while busy: next accept only after done; back-to-back spacing ROWS+2.
    r = '{1, 4'd4, 32'h0000_8000, 32'h8, 0, 32'h0000_8018, 5};
    run_cmd(vecs[2], 1'b1, r);
    prev_acc = acc_cyc;
    run_cmd(r, 1'b0, none);
    check("b2b_spacing", 64'(acc_cyc - prev_acc), 64'(ROWS + 2));

    // Spurious hits in IDLE must cause no activity.
    mem_hit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_quiet("spurious_hit");
      tick();
    end
    mem_hit = 1'b0;
    check_quiet("spurious_after");

    // Random commands against the per-row model.
    for (int i = 0; i < 20; i++) begin
      r.load   = 1'($urandom_range(0, 1));
      r.mreg   = 4'($urandom_range(0, 15));
      r.base   = $urandom();
      r.stride = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
      r.lat    = $urandom_range(0, 3);
      r.exp_last = r.base + r.stride * 32'(ROWS - 1);
      r.exp_done = r.load ? 1 + ROWS * (r.lat + 1) : 1 + ROWS * (r.lat + 2);
      run_cmd(r, 1'b0, none);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/matrix_ls_sequencer.md
MATRIX_LS_SEQUENCER -- requirements
Module: matrix_ls_sequencer

Interface
REQ-001 Parameter ROWS, default 4, SHALL set the number of matrix rows per command (power of two, >=2).
REQ-002 Parameter ADDR_W, default 32, SHALL set the memory address width.
REQ-003 Parameter DATA_W, default 64, SHALL set the width of one matrix row (4 x fp16).
REQ-004 Parameter MREG_W, default 4, SHALL set the matrix register index width.
REQ-005 One clock; reset is synchronous and active-high. Ports:
  CLK  in  1  clock, all state on rising edge
  RST  in  1  synchronous reset, active-high
  cmd_valid  in  1  command offered
  cmd_ready  out  1  sequencer idle, command accepted when cmd_valid&cmd_ready
  cmd_load  in  1  1=matrix load, 0=matrix store
  cmd_mreg  in  MREG_W  matrix register (load destination / store source)
  cmd_base  in  ADDR_W  base address (rs+imm)
  cmd_stride  in  ADDR_W  byte stride between rows
  mem_req  out  1  memory request pending
  mem_wen  out  1  request is a write
  mem_addr  out  ADDR_W  row address
  mem_wdata  out  DATA_W  store row data
  mem_hit  in  1  one-cycle completion pulse (mhit)
  mem_rdata  in  DATA_W  load row data, valid with mem_hit
  mrf_wen  out  1  matrix RF row write
  mrf_ren  out  1  matrix RF row read
  mrf_reg  out  MREG_W  matrix register index
  mrf_row  out  log2(ROWS)  row index
  mrf_wdata  out  DATA_W  row write data
  mrf_rdata  in  DATA_W  row read data, valid one cycle after mrf_ren
  busy  out  1  command in flight
  done  out  1  one-cycle completion pulse

Function
REQ-006 FSM states SHALL be IDLE, RDREG, REQ, DONE.
REQ-007 cmd_ready SHALL equal (state==IDLE); busy SHALL equal its inverse.
REQ-008 On accept: latch load flag, mreg, base into addr register, stride; row counter <= 0; next state REQ if load, RDREG if store.
REQ-009 cmd_valid outside IDLE SHALL be ignored (no latch, no state change).
REQ-010 RDREG: mrf_ren=1 for exactly one cycle, mrf_row=row counter; next cycle state REQ and mrf_rdata captured into the wdata register.
REQ-011 REQ: mem_req=1, mem_wen=~load, mem_addr=addr register, mem_wdata=wdata register; held stable until mem_hit.
REQ-012 Load, REQ with mem_hit: mrf_wen=1 in the same cycle, mrf_wdata=mem_rdata, mrf_row=row counter.
REQ-013 REQ with mem_hit, row counter < ROWS-1: row counter +1, addr += stride (mod 2^ADDR_W), next state REQ (load) or RDREG (store); mem_hit consumes the request, so a continuously high mem_req with a new address is a new request.
REQ-014 REQ with mem_hit, row counter == ROWS-1: next state DONE.
REQ-015 DONE: done=1 for one cycle, next state IDLE.
REQ-016 mem_hit outside REQ SHALL be ignored.
REQ-017 Stride 0 SHALL be legal: all rows access the same address.
REQ-018 Outside their active states, mem_req, mem_wen, mrf_wen, mrf_ren and done SHALL be 0.
REQ-019 mrf_reg SHALL equal the latched mreg whenever busy.
REQ-020 Latency, load with zero-wait hits: accept cycle 0, REQ cycles 1..ROWS, done at cycle ROWS+1, cmd_ready at ROWS+2. Store adds one RDREG cycle per row.

Reset
REQ-021 RST high at a clock edge SHALL force IDLE and clear row counter, addr, wdata and all latched fields to 0.
REQ-022 Reset mid-command SHALL abort the command with no done pulse; cmd_ready=1 in the first cycle after reset deasserts.
REQ-023 During and after reset, all outputs except cmd_ready SHALL be 0.

Verification
REQ-024 Load mreg=3, base 0x100, stride 0x40, hit 2 cycles after each request -> addrs 0x100,0x140,0x180,0x1C0; mrf_wen rows 0..3 of reg 3 with mem_rdata; one done pulse.
REQ-025 Store mreg=5, base 0x2000, stride 0x8, RF rows = 0xA0..0xA3 -> mrf_ren rows 0..3, mem_wen=1, mem_wdata 0xA0..0xA3 at 0x2000..0x2018; one done.
REQ-026 Load base 0xFFFFFFC0, stride 0x20 -> addrs 0xFFFFFFC0, 0xFFFFFFE0, 0x00000000, 0x00000020.
REQ-027 Reset asserted while waiting on row 2 hit -> no done, mem_req=0 next cycle, cmd_ready=1 after release; a new load runs cleanly from row 0.
REQ-028 cmd_valid held high while busy and mem_hit pulsed in IDLE -> second command accepted only after done; spurious hit causes no activity.
REQ-029 Back-to-back loads, zero-wait hits -> second accept exactly ROWS+2 cycles after the first.
